// File: rtl/serial_audio_encoder.sv
// -----------------------------------------------------------------------------
// serial_audio_encoder
//
// Serial audio transmitter. It takes tagged left/right PCM samples over a
// valid/ready handshake and holds at most one sample per channel. Frames are
// sent MSB-first on lrclk/sdout, either left-justified or I2S, with 16-, 24-
// or 32-bit slots. It is the counterpart of the serial audio decoder.
//
// Parameters
//   audio_width    width of i_audio (1..32). The sample is MSB-aligned into
//                  the slot word. Short samples are zero-padded and long
//                  samples are truncated at the LSB end.
//
// Ports
//   sclk           bit clock; all logic runs on posedge
//   reset          asynchronous, active-high
//   enable         1 = run frames, 0 = idle (aborts the current frame)
//   is_i2s         1 = data delayed one bit after the lrclk edge
//                  0 = left-justified
//   lrclk_polarity lrclk level that marks the left slot (static while running)
//   word_len       00 = 16, 01 = 24, 1x = 32 bit slots
//   i_valid        sample present
//   i_ready        sample accepted when i_valid && i_ready
//   i_is_left      channel tag of the offered sample
//   i_audio        sample, MSB first
//   lrclk          frame clock
//   sdout          serial data
//   underrun       one-cycle pulse: a slot started with its channel buffer empty
// -----------------------------------------------------------------------------
module serial_audio_encoder #(
  parameter int audio_width = 32
) (
  input  logic                   sclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   is_i2s,
  input  logic                   lrclk_polarity,
  input  logic [1:0]             word_len,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  output logic                   lrclk,
  output logic                   sdout,
  output logic                   underrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Channel index used for the buffers and for the slot register.
  localparam logic SLOT_LEFT  = 1'b0;
  localparam logic SLOT_RIGHT = 1'b1;

  // Places the sample in the top bits of a 32-bit word and zero-fills the rest.
  // A slot of N bits then sends the top N bits of this word.
  function automatic logic [31:0] align_word(input logic [audio_width-1:0] sample);
    logic [31:0] word;
    word = 32'd0;
    word[31 -: audio_width] = sample;
    return word;
  endfunction

  // Index of the last bit in a slot for a given word_len code.
  function automatic logic [4:0] last_bit(input logic [1:0] len);
    logic [4:0] lb;
    case (len)
      2'b00:   lb = 5'd15;
      2'b01:   lb = 5'd23;
      default: lb = 5'd31;
    endcase
    return lb;
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             slot_q, slot_d;
  logic [1:0]       len_q, len_d;
  logic [31:0]      shift_q, shift_d;
  logic             dly_q, dly_d;
  logic             sdout_q, sdout_d;
  logic             underrun_q, underrun_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][31:0] buf_q, buf_d;

  logic             wr_ch;
  logic             wr_en;
  logic             slot_start;
  logic             new_slot;

  assign wr_ch   = i_is_left ? SLOT_LEFT : SLOT_RIGHT;
  assign i_ready = ~full_q[wr_ch];
  assign wr_en   = i_valid & i_ready;

  // lrclk follows the slot flop directly. Polarity is static while frames
  // run, so it can be applied after the flop without glitching the output.
  // This also makes the reset value equal to lrclk_polarity.
  assign lrclk    = slot_q ^ lrclk_polarity;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

  // Next-state logic: frame sequencing, slot loads, data output and buffers.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    len_d      = len_q;
    shift_d    = shift_q;
    dly_d      = dly_q;
    sdout_d    = sdout_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    buf_d      = buf_q;
    slot_start = 1'b0;
    new_slot   = slot_q;

    case (state_q)
      ST_IDLE: begin
        // Counters wait at the start of a frame.
        bit_cnt_d = 5'd0;
        slot_d    = SLOT_LEFT;
        shift_d   = 32'd0;
        if (enable) begin
          state_d    = ST_RUN;
          slot_start = 1'b1;
          new_slot   = SLOT_LEFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // Abort the frame. Buffers that were not yet drained keep their data.
          state_d   = ST_IDLE;
          bit_cnt_d = 5'd0;
          slot_d    = SLOT_LEFT;
          shift_d   = 32'd0;
        end else if (bit_cnt_q == last_bit(len_q)) begin
          slot_start = 1'b1;
          new_slot   = ~slot_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          shift_d   = {shift_q[30:0], 1'b0};
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 5'd0;
        slot_d    = SLOT_LEFT;
        shift_d   = 32'd0;
      end
    endcase

    // Slot load. An empty buffer sends silence and flags an underrun.
    if (slot_start) begin
      bit_cnt_d            = 5'd0;
      slot_d               = new_slot;
      shift_d              = full_q[new_slot] ? buf_q[new_slot] : 32'd0;
      underrun_d           = ~full_q[new_slot];
      full_d[new_slot]     = 1'b0;
      // Slot length only changes at frame boundaries.
      len_d                = (new_slot == SLOT_LEFT) ? word_len : len_q;
    end else begin
      len_d = len_q;
    end

    // shift_d[31] is the left-justified bit for the coming cycle. I2S sends
    // the bit from one cycle earlier, so the first slot after idle sends 0.
    if (state_d == ST_RUN) begin
      dly_d   = shift_d[31];
      sdout_d = is_i2s ? dly_q : shift_d[31];
    end else begin
      dly_d   = 1'b0;
      sdout_d = 1'b0;
    end

    // Buffer write. i_ready is low for a full buffer, so a write can never
    // overwrite a word that is waiting. A write to a buffer being drained in
    // the same cycle only occurs when that buffer was already empty.
    full_d[wr_ch] = full_d[wr_ch] | wr_en;
    buf_d[wr_ch]  = wr_en ? align_word(i_audio) : buf_d[wr_ch];
  end

  // State and output registers.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 5'd0;
      slot_q     <= SLOT_LEFT;
      len_q      <= 2'b00;
      shift_q    <= 32'd0;
      dly_q      <= 1'b0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 2'b00;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      dly_q      <= dly_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      buf_q      <= buf_d;
    end
  end

endmodule
